// File: rtl/alu_pkg.sv
// Shared encodings and elaboration helpers for the slice-serial ALU.
package alu_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_NAND = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_ZERO   = 2'b01;
    localparam logic [1:0] COND_CARRY  = 2'b10;
    localparam logic [1:0] COND_RSVD   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned num_slices(input int unsigned width, input int unsigned slice);
        return (slice == 0) ? 1 : width / slice;
    endfunction

    function automatic logic slice_fits(input int unsigned width, input int unsigned slice);
        return (slice != 0) && ((width % slice) == 0);
    endfunction

    // Reserved condition code behaves as "always".
    function automatic logic cond_met(input logic [1:0] cnd, input logic c_flag, input logic z_flag);
        case (cnd)
            COND_ZERO:  return z_flag;
            COND_CARRY: return c_flag;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic is_arith(input logic [1:0] opc);
        return (opc == OP_ADD) || (opc == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU step; reused every BUSY cycle by the top level.
module alu_slice
    import alu_pkg::*;
#(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic [SLICE-1:0] res,
    output logic             cout,
    output logic             res_zero
);

    logic [SLICE-1:0] w_b;
    logic [SLICE:0]   w_sum;

    // SUB is a + ~b with the chain carry seeded to 1 by the caller.
    always_comb begin
        w_b   = (op == OP_SUB) ? ~b : b;
        w_sum = {1'b0, a} + {1'b0, w_b} + {{SLICE{1'b0}}, cin};
        if (is_arith(op)) begin
            res  = w_sum[SLICE-1:0];
            cout = w_sum[SLICE];
        end else begin
            res  = ~(a & b);
            cout = cin;
        end
        res_zero = (res == '0);
    end

endmodule

// File: rtl/alu_multicycle.sv
// Slice-serial ADD/NAND/SUB execute unit with architectural carry/zero flags
// and conditional execution checked at acceptance.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [1:0]       cond,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             ready,
    output logic             done,
    output logic             wr_en,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero,
    output logic             eq,
    output logic             neg
);

    localparam int unsigned NS    = num_slices(WIDTH, SLICE);
    localparam int unsigned CNT_W = (NS > 1) ? $clog2(NS) : 1;
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    generate
        if (!slice_fits(WIDTH, SLICE)) begin : g_bad_slice
            $error("alu_multicycle: WIDTH must be a non-zero multiple of SLICE");
        end
    endgenerate

    state_e             r_state;
    state_e             w_state_nxt;
    logic               w_accept;
    logic               w_last;

    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [1:0]         r_op;
    logic               r_cin;
    logic               r_zacc;
    logic [WIDTH-1:0]   r_res;

    logic [WIDTH-1:0]   r_out;
    logic               r_carry;
    logic               r_zero;
    logic               r_eq;
    logic               r_wr_en;

    logic [IDX_W-1:0]   w_base;
    logic [SLICE-1:0]   w_a;
    logic [SLICE-1:0]   w_b;
    logic [SLICE-1:0]   w_slice_res;
    logic               w_cout;
    logic               w_slice_zero;
    logic [WIDTH-1:0]   w_res_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Condition is judged against the flag registers as they stand at acceptance.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (cond_met(cond, r_carry, r_zero)) begin
                        w_state_nxt = BUSY;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            BUSY: begin
                if (r_cnt == CNT_W'(NS - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_base    = IDX_W'(32'(r_cnt) * SLICE);
        w_a       = r_a[w_base +: SLICE];
        w_b       = r_b[w_base +: SLICE];
        w_res_nxt = r_res;
        w_res_nxt[w_base +: SLICE] = w_slice_res;
    end

    alu_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a        (w_a),
        .b        (w_b),
        .cin      (r_cin),
        .op       (r_op),
        .res      (w_slice_res),
        .cout     (w_cout),
        .res_zero (w_slice_zero)
    );

    // Operand capture and per-slice chain state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_op   <= OP_ADD;
            r_cin  <= 1'b0;
            r_zacc <= 1'b0;
            r_res  <= '0;
        end else if (w_accept) begin
            r_a    <= in1;
            r_b    <= in2;
            r_op   <= op;
            r_cin  <= (op == OP_SUB);
            r_zacc <= 1'b1;
            r_cnt  <= '0;
        end else if (r_state == BUSY) begin
            r_res  <= w_res_nxt;
            r_cin  <= w_cout;
            r_zacc <= r_zacc & w_slice_zero;
            r_cnt  <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

    // Architectural state commits only on the last slice of an executed op.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out   <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
            r_eq    <= 1'b0;
            r_wr_en <= 1'b0;
        end else begin
            r_wr_en <= w_last;
            if (w_accept) begin
                r_eq <= (in1 == in2);
            end
            if (w_last) begin
                r_out  <= w_res_nxt;
                r_zero <= r_zacc & w_slice_zero;
                if (is_arith(r_op)) begin
                    r_carry <= w_cout;
                end
            end
        end
    end

    assign ready = (r_state == IDLE);
    assign done  = (r_state == DONE);
    assign wr_en = r_wr_en;
    assign out   = r_out;
    assign carry = r_carry;
    assign zero  = r_zero;
    assign eq    = r_eq;
    assign neg   = r_out[WIDTH-1];

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: three instances (SLICE 4, 16, 1) checked against a
// plain-arithmetic reference of the flag/condition rules.
module tb_alu_multicycle;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]         rst_v;
    logic [2:0]         start_v;
    logic [2:0][1:0]    op_v;
    logic [2:0][1:0]    cond_v;
    logic [2:0][W-1:0]  in1_v;
    logic [2:0][W-1:0]  in2_v;
    logic [2:0]         ready_v;
    logic [2:0]         done_v;
    logic [2:0]         wr_en_v;
    logic [2:0][W-1:0]  out_v;
    logic [2:0]         carry_v;
    logic [2:0]         zero_v;
    logic [2:0]         eq_v;
    logic [2:0]         neg_v;

    alu_multicycle #(.WIDTH(W), .SLICE(4)) u_dut0 (
        .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .op(op_v[0]), .cond(cond_v[0]),
        .in1(in1_v[0]), .in2(in2_v[0]), .ready(ready_v[0]), .done(done_v[0]),
        .wr_en(wr_en_v[0]), .out(out_v[0]), .carry(carry_v[0]), .zero(zero_v[0]),
        .eq(eq_v[0]), .neg(neg_v[0]));

    alu_multicycle #(.WIDTH(W), .SLICE(16)) u_dut1 (
        .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .op(op_v[1]), .cond(cond_v[1]),
        .in1(in1_v[1]), .in2(in2_v[1]), .ready(ready_v[1]), .done(done_v[1]),
        .wr_en(wr_en_v[1]), .out(out_v[1]), .carry(carry_v[1]), .zero(zero_v[1]),
        .eq(eq_v[1]), .neg(neg_v[1]));

    alu_multicycle #(.WIDTH(W), .SLICE(1)) u_dut2 (
        .clk(clk), .reset(rst_v[2]), .start(start_v[2]), .op(op_v[2]), .cond(cond_v[2]),
        .in1(in1_v[2]), .in2(in2_v[2]), .ready(ready_v[2]), .done(done_v[2]),
        .wr_en(wr_en_v[2]), .out(out_v[2]), .carry(carry_v[2]), .zero(zero_v[2]),
        .eq(eq_v[2]), .neg(neg_v[2]));

    int total = 0;
    int bad   = 0;
    int cur   = 0;

    // Reference architectural state per instance.
    logic [2:0][W-1:0] m_out;
    logic [2:0]        m_carry;
    logic [2:0]        m_zero;
    logic [2:0]        m_eq;

    function automatic int ns_of(input int d);
        case (d)
            0:       return 4;
            1:       return 1;
            default: return 16;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s dut=%0d observed=%0h expected=%0h", tag, cur, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns whether the op executes; updates the reference flags/result.
    task automatic model_op(input int d, input logic [1:0] o, input logic [1:0] c,
                            input logic [W-1:0] a, input logic [W-1:0] b, output logic ex);
        logic [31:0] sum;
        case (c)
            2'b10:   ex = m_carry[d];
            2'b01:   ex = m_zero[d];
            default: ex = 1'b1;
        endcase
        m_eq[d] = (a == b);
        if (ex) begin
            case (o)
                2'b00: begin
                    sum        = 32'(a) + 32'(b);
                    m_out[d]   = W'(sum);
                    m_carry[d] = sum[W];
                end
                2'b10: begin
                    m_out[d]   = a - b;
                    m_carry[d] = (a >= b);
                end
                default: m_out[d] = ~(a & b);
            endcase
            m_zero[d] = (m_out[d] == '0);
        end
    endtask

    task automatic check_outputs(input int d, input logic ex);
        check("wr_en", 32'(wr_en_v[d]), 32'(ex));
        check("out",   32'(out_v[d]),   32'(m_out[d]));
        check("carry", 32'(carry_v[d]), 32'(m_carry[d]));
        check("zero",  32'(zero_v[d]),  32'(m_zero[d]));
        check("eq",    32'(eq_v[d]),    32'(m_eq[d]));
        check("neg",   32'(neg_v[d]),   32'(m_out[d][W-1]));
    endtask

    task automatic check_reset_state(input int d);
        check("rst_ready", 32'(ready_v[d]), 32'd1);
        check("rst_done",  32'(done_v[d]),  32'd0);
        check("rst_wr_en", 32'(wr_en_v[d]), 32'd0);
        check("rst_out",   32'(out_v[d]),   32'd0);
        check("rst_carry", 32'(carry_v[d]), 32'd0);
        check("rst_zero",  32'(zero_v[d]),  32'd0);
        check("rst_eq",    32'(eq_v[d]),    32'd0);
        check("rst_neg",   32'(neg_v[d]),   32'd0);
    endtask

    task automatic do_reset(input int d);
        rst_v[d] = 1'b1;
        tick();
        tick();
        check_reset_state(d);
        rst_v[d]   = 1'b0;
        m_out[d]   = '0;
        m_carry[d] = 1'b0;
        m_zero[d]  = 1'b0;
        m_eq[d]    = 1'b0;
    endtask

    // One start pulse, then latency and result checks.
    task automatic do_op(input int d, input logic [1:0] o, input logic [1:0] c,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        logic ex;
        int   k;
        k = 0;
        while (!ready_v[d] && k < 40) begin
            tick();
            k++;
        end
        check("ready_before_start", 32'(ready_v[d]), 32'd1);
        model_op(d, o, c, a, b, ex);
        start_v[d] = 1'b1;
        op_v[d]    = o;
        cond_v[d]  = c;
        in1_v[d]   = a;
        in2_v[d]   = b;
        tick();
        start_v[d] = 1'b0;
        in1_v[d]   = W'($urandom);
        in2_v[d]   = W'($urandom);
        k = 0;
        while (!done_v[d] && k < 40) begin
            tick();
            k++;
        end
        check("done_latency", 32'(k), ex ? 32'(ns_of(d)) : 32'd0);
        check_outputs(d, ex);
        tick();
        check("done_pulse_len", 32'(done_v[d]), 32'd0);
        check("ready_after",    32'(ready_v[d]), 32'd1);
    endtask

    initial begin
        logic [1:0]   o;
        logic [1:0]   c;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ex;
        logic         prev_ex;
        logic         pend;
        logic         pend_ex;
        logic [W-1:0] p_out;
        logic         p_carry;
        logic         p_zero;
        logic         p_eq;
        int           last_acc;
        int           seen;
        int           accepts;

        rst_v   = '1;
        start_v = '0;
        op_v    = '0;
        cond_v  = '0;
        in1_v   = '0;
        in2_v   = '0;
        m_out   = '0;
        m_carry = '0;
        m_zero  = '0;
        m_eq    = '0;
        prev_ex = 1'b0;

        for (int d = 0; d < 3; d++) begin
            cur = d;
            do_reset(d);

            // Directed sequence from the flag/condition rules.
            do_op(d, 2'b00, 2'b00, 16'hFFFF, 16'h0001);
            do_op(d, 2'b01, 2'b00, 16'hFFFF, 16'h00FF);
            do_op(d, 2'b00, 2'b10, 16'h0001, 16'h0002);
            do_op(d, 2'b10, 2'b00, 16'h1234, 16'h1234);
            do_op(d, 2'b10, 2'b00, 16'h0001, 16'h0002);
            do_op(d, 2'b00, 2'b10, 16'h0005, 16'h0005);
            do_op(d, 2'b00, 2'b01, 16'h0007, 16'h0009);
            do_op(d, 2'b10, 2'b00, 16'h8000, 16'h8000);
            do_op(d, 2'b11, 2'b01, 16'hF0F0, 16'h0FF0);
            do_op(d, 2'b00, 2'b11, 16'h8000, 16'h8000);

            // Random ops; equal/complementary operands now and then to hit flags.
            for (int i = 0; i < 25; i++) begin
                a = W'($urandom);
                case ($urandom_range(0, 3))
                    0:       b = a;
                    1:       b = W'(0) - a;
                    default: b = W'($urandom);
                endcase
                do_op(d, 2'($urandom), 2'($urandom), a, b);
            end

            // Reset during the second BUSY cycle discards the op.
            if (ns_of(d) >= 2) begin
                start_v[d] = 1'b1;
                op_v[d]    = 2'b00;
                cond_v[d]  = 2'b00;
                in1_v[d]   = 16'h00FF;
                in2_v[d]   = 16'h0001;
                tick();
                start_v[d] = 1'b0;
                tick();
                rst_v[d] = 1'b1;
                tick();
                check_reset_state(d);
                rst_v[d]   = 1'b0;
                m_out[d]   = '0;
                m_carry[d] = 1'b0;
                m_zero[d]  = 1'b0;
                m_eq[d]    = 1'b0;
                seen = 0;
                for (int i = 0; i < ns_of(d) + 4; i++) begin
                    tick();
                    if (done_v[d]) seen++;
                end
                check("no_done_after_reset", 32'(seen), 32'd0);
            end

            // start held high with operands changing every cycle.
            last_acc   = -1;
            pend       = 1'b0;
            pend_ex    = 1'b0;
            p_out      = '0;
            p_carry    = 1'b0;
            p_zero     = 1'b0;
            p_eq       = 1'b0;
            accepts    = 0;
            start_v[d] = 1'b1;
            for (int cyc = 0; cyc < 70; cyc++) begin
                o = 2'($urandom);
                c = 2'($urandom);
                a = W'($urandom);
                b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
                op_v[d]   = o;
                cond_v[d] = c;
                in1_v[d]  = a;
                in2_v[d]  = b;
                if (ready_v[d]) begin
                    model_op(d, o, c, a, b, ex);
                    if (last_acc >= 0) begin
                        check("held_spacing", 32'(cyc - last_acc),
                              prev_ex ? 32'(ns_of(d) + 2) : 32'd2);
                    end
                    last_acc = cyc;
                    prev_ex  = ex;
                    pend     = 1'b1;
                    pend_ex  = ex;
                    p_out    = m_out[d];
                    p_carry  = m_carry[d];
                    p_zero   = m_zero[d];
                    p_eq     = m_eq[d];
                    accepts++;
                end
                tick();
                if (done_v[d]) begin
                    check("held_done_expected", 32'(pend), 32'd1);
                    check("held_wr_en", 32'(wr_en_v[d]), 32'(pend_ex));
                    check("held_out",   32'(out_v[d]),   32'(p_out));
                    check("held_carry", 32'(carry_v[d]), 32'(p_carry));
                    check("held_zero",  32'(zero_v[d]),  32'(p_zero));
                    check("held_eq",    32'(eq_v[d]),    32'(p_eq));
                    pend = 1'b0;
                end
            end
            start_v[d] = 1'b0;
            for (int i = 0; i < 20 && pend; i++) begin
                tick();
                if (done_v[d]) begin
                    check("drain_out",   32'(out_v[d]),   32'(p_out));
                    check("drain_carry", 32'(carry_v[d]), 32'(p_carry));
                    pend = 1'b0;
                end
            end
            check("held_drained", 32'(pend), 32'd0);
            check("held_accepts_min", 32'(accepts >= 3), 32'd1);
            tick();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
